// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment scan driver for the digital clock.
// Display content arrives over a valid/ready port into a shadow buffer and is committed
// to the active buffer only at frame boundaries (slot 3 -> slot 0), so frames never tear.
// Cycle 0 of every digit slot is a ghost guard with anodes and segments off.
// Optional feature macro: SEG7_DIM_EN adds a 3-bit `bright` input for PWM dimming of the anodes.

module seg7_scan_driver #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
`ifdef SEG7_DIM_EN
    input  logic [2:0]  bright,
`endif
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [7:0]  ca
);

    localparam int unsigned SCAN_DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
`ifdef SEG7_DIM_EN
    localparam int unsigned SUB_LEN  = SCAN_DIV / 8;
`endif

    // Slot timing
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             frame_tick_q, frame_tick_d;

    // Active (displayed) buffer
    logic [15:0]      act_bcd_q, act_bcd_d;
    logic [3:0]       act_dp_q, act_dp_d;
    logic             act_blz_q, act_blz_d;

    // Shadow (pending) buffer
    logic [15:0]      sh_bcd_q, sh_bcd_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic             sh_blz_q, sh_blz_d;
    logic             sh_full_q, sh_full_d;
    logic             upd_ready_q, upd_ready_d;

    // Display outputs
    logic [3:0]       an_q, an_d;
    logic [7:0]       ca_q, ca_d;

    // Decoded digit helpers
    logic [3:0]       dig0, dig1, dig2, dig3, sel_dig;
    logic             lz1, lz2, lz3, sel_blank;
    logic             slot_last;
    logic             xfer;
    logic             commit;

    assign upd_ready  = upd_ready_q;
    assign frame_tick = frame_tick_q;
    assign an         = an_q;
    assign ca         = ca_q;

    // BCD to segment pattern a..g; non-decimal codes render blank
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Next-state: slot timing, handshake, commit and registered display outputs
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        act_blz_d    = act_blz_q;
        sh_bcd_d     = sh_bcd_q;
        sh_dp_d      = sh_dp_q;
        sh_blz_d     = sh_blz_q;
        sh_full_d    = sh_full_q;
        an_d         = 4'b0000;
        ca_d         = 8'h00;

        // slot counter and digit index
        slot_last = (cnt_q == CNT_W'(SCAN_DIV - 1));
        if (slot_last) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        frame_tick_d = slot_last && (idx_q == 2'd3);

        // transfer and commit are exclusive: one needs the shadow empty, the other full
        xfer   = upd_valid && upd_ready_q;
        commit = frame_tick_q && sh_full_q;
        if (commit) begin
            act_bcd_d = sh_bcd_q;
            act_dp_d  = sh_dp_q;
            act_blz_d = sh_blz_q;
            sh_full_d = 1'b0;
        end
        if (xfer) begin
            sh_bcd_d  = bcd_in;
            sh_dp_d   = dp_in;
            sh_blz_d  = blank_lz;
            sh_full_d = 1'b1;
        end
        upd_ready_d = ~sh_full_d;

        // leading-zero blanking chain from the most significant digit down
        dig0 = act_bcd_q[3:0];
        dig1 = act_bcd_q[7:4];
        dig2 = act_bcd_q[11:8];
        dig3 = act_bcd_q[15:12];
        lz3  = act_blz_q && (dig3 == 4'd0);
        lz2  = lz3 && (dig2 == 4'd0);
        lz1  = lz2 && (dig1 == 4'd0);

        case (idx_q)
            2'd0:    begin sel_dig = dig0; sel_blank = 1'b0; end
            2'd1:    begin sel_dig = dig1; sel_blank = lz1;  end
            2'd2:    begin sel_dig = dig2; sel_blank = lz2;  end
            default: begin sel_dig = dig3; sel_blank = lz3;  end
        endcase

        // guard cycle keeps everything dark; otherwise drive the selected digit
        if (cnt_q != '0) begin
            an_d = 4'b0001 << idx_q;
            ca_d = {act_dp_q[idx_q], sel_blank ? 7'h00 : glyph(sel_dig)};
`ifdef SEG7_DIM_EN
            if (32'(cnt_q) >= (32'(bright) + 32'd1) * SUB_LEN) begin
                an_d = 4'b0000;
            end
`endif
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            frame_tick_q <= 1'b0;
            act_bcd_q    <= 16'hFFFF;
            act_dp_q     <= 4'b0000;
            act_blz_q    <= 1'b0;
            sh_bcd_q     <= 16'h0000;
            sh_dp_q      <= 4'b0000;
            sh_blz_q     <= 1'b0;
            sh_full_q    <= 1'b0;
            upd_ready_q  <= 1'b1;
            an_q         <= 4'b0000;
            ca_q         <= 8'h00;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_tick_q <= frame_tick_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            act_blz_q    <= act_blz_d;
            sh_bcd_q     <= sh_bcd_d;
            sh_dp_q      <= sh_dp_d;
            sh_blz_q     <= sh_blz_d;
            sh_full_q    <= sh_full_d;
            upd_ready_q  <= upd_ready_d;
            an_q         <= an_d;
            ca_q         <= ca_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: directed scenarios plus randomized traffic, each cycle
// compared against a frame-level reference model of the display.

module tb_seg7_scan_driver;

    localparam int unsigned CLK_HZ     = 8000;
    localparam int unsigned REFRESH_HZ = 1000;
    localparam int unsigned SCAN_DIV   = CLK_HZ / REFRESH_HZ;
    localparam int unsigned FRAME      = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        frame_tick;
    logic [3:0]  an;
    logic [7:0]  ca;
`ifdef SEG7_DIM_EN
    logic [2:0]  bright;
`endif

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
`ifdef SEG7_DIM_EN
        .bright     (bright),
`endif
        .frame_tick (frame_tick),
        .an         (an),
        .ca         (ca)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: edges since reset, displayed and pending payloads
    int unsigned n;
    logic [15:0] m_act_bcd, m_sh_bcd;
    logic [3:0]  m_act_dp, m_sh_dp;
    logic        m_act_blz, m_sh_blz, m_full;
    logic [6:0]  glyph_tab [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Expected segment byte for a digit position of the currently displayed payload
    function automatic logic [7:0] seg_for(input int slot);
        logic [3:0] d;
        logic [15:0] v;
        bit blanked;
        v = m_act_bcd >> (4 * slot);
        d = v[3:0];
        blanked = 0;
        if (m_act_blz && slot > 0) begin
            // a position is a leading zero when it and every higher digit is zero
            blanked = 1;
            for (int k = 3; k >= slot; k--) begin
                v = m_act_bcd >> (4 * k);
                if (v[3:0] != 4'd0) blanked = 0;
            end
        end
        return {m_act_dp[slot], blanked ? 7'h00 : glyph_tab[d]};
    endfunction

    task automatic model_reset();
        n         = 0;
        m_act_bcd = 16'hFFFF;
        m_act_dp  = 4'b0000;
        m_act_blz = 1'b0;
        m_full    = 1'b0;
    endtask

    // Advance one clock with the current inputs and compare all outputs
    task automatic step();
        int sc;
        int slot;
        logic [3:0] e_an;
        logic [7:0] e_ca;
        logic e_ft;
        bit commit;
        bit xfer;
        sc   = int'(n % SCAN_DIV);
        slot = int'((n / SCAN_DIV) % 4);
        e_an = 4'b0000;
        e_ca = 8'h00;
        if (sc != 0) begin
            e_ca = seg_for(slot);
            e_an = 4'(1 << slot);
`ifdef SEG7_DIM_EN
            if (sc / int'(SCAN_DIV / 8) > int'(bright)) e_an = 4'b0000;
`endif
        end
        e_ft   = (n % FRAME) == (FRAME - 1);
        commit = (n > 0) && (n % FRAME == 0) && m_full;
        xfer   = upd_valid && !m_full;
        if (commit) begin
            m_act_bcd = m_sh_bcd;
            m_act_dp  = m_sh_dp;
            m_act_blz = m_sh_blz;
            m_full    = 1'b0;
        end
        if (xfer) begin
            m_sh_bcd = bcd_in;
            m_sh_dp  = dp_in;
            m_sh_blz = blank_lz;
            m_full   = 1'b1;
        end
        n++;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("ca", 32'(ca), 32'(e_ca));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        check("upd_ready", 32'(upd_ready), 32'(!m_full));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'h0);
        check("rst_ca", 32'(ca), 32'h0);
        check("rst_ready", 32'(upd_ready), 32'h1);
        check("rst_ftick", 32'(frame_tick), 32'h0);
        upd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Offer a payload and hold valid until it is taken; optionally leave valid high
    task automatic offer(input logic [15:0] b, input logic [3:0] d, input logic z, input bit keep);
        bit taken;
        bcd_in    = b;
        dp_in     = d;
        blank_lz  = z;
        upd_valid = 1'b1;
        taken     = 0;
        for (int i = 0; i < 4 * FRAME && !taken; i++) begin
            taken = !m_full;
            step();
        end
        check("offer_taken", 32'(taken), 32'h1);
        if (!keep) upd_valid = 1'b0;
    endtask

    task automatic run_to_phase(input int unsigned ph);
        for (int i = 0; i < int'(FRAME) + 1 && !((n % FRAME) == ph && n > 0); i++) step();
    endtask

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        rst       = 1'b1;
        upd_valid = 1'b0;
        bcd_in    = 16'h0000;
        dp_in     = 4'b0000;
        blank_lz  = 1'b0;
`ifdef SEG7_DIM_EN
        bright    = 3'd7;
`endif
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        run(2 * FRAME);

        // Plain digits, no decimal points
        offer(16'h1234, 4'b0000, 1'b0, 0);
        run(2 * FRAME);

        // Leading-zero blanking with a decimal point on digit 1
        offer(16'h0070, 4'b0010, 1'b1, 0);
        run(2 * FRAME);
        offer(16'h0000, 4'b0000, 1'b1, 0);
        run(2 * FRAME);
        offer(16'hABCD, 4'b1111, 1'b0, 0);
        run(2 * FRAME);

        // Back-to-back payloads with valid held high
        offer(16'h2468, 4'b0101, 1'b0, 1);
        offer(16'h1357, 4'b1010, 1'b0, 0);
        run(3 * FRAME);

        // Transfer coinciding with frame_tick while the shadow is empty
        run_to_phase(0);
        offer(16'h0905, 4'b0000, 1'b1, 0);
        run(3 * FRAME);

        // Reset while the shadow holds pending data
        run_to_phase(2);
        offer(16'h5678, 4'b1000, 1'b0, 0);
        run(3);
        do_reset();
        run(2 * FRAME);

`ifdef SEG7_DIM_EN
        // Dimming: one active cycle per slot, then full brightness
        offer(16'h8888, 4'b0000, 1'b0, 0);
        bright = 3'd1;
        run(2 * FRAME);
        bright = 3'd7;
        run(FRAME);
`endif

        // Randomized traffic, with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            upd_valid = ($urandom_range(0, 3) == 0);
            bcd_in    = 16'($urandom);
            dp_in     = 4'($urandom);
            blank_lz  = 1'($urandom);
`ifdef SEG7_DIM_EN
            bright    = 3'($urandom);
`endif
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end
        upd_valid = 1'b0;
        run(FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
